// File: rtl/dma_io_responder_if.sv
// DMA channel bus between an 8237A-style controller and one device.
// The controller side is master, the device endpoint is slave.
interface dma_io_responder_if #(
  parameter int DATA_W = 8
);
  logic              DREQ;
  logic              DACK;
  logic              IOR_N;
  logic              IOW_N;
  logic              EOP_N_IN;
  logic              EOP_N_OUT;
  logic [DATA_W-1:0] DB_IN;
  logic [DATA_W-1:0] DB_OUT;
  logic              DB_OE;

  modport master (
    input  DREQ, EOP_N_OUT, DB_OUT, DB_OE,
    output DACK, IOR_N, IOW_N, EOP_N_IN, DB_IN
  );

  modport slave (
    output DREQ, EOP_N_OUT, DB_OUT, DB_OE,
    input  DACK, IOR_N, IOW_N, EOP_N_IN, DB_IN
  );
endinterface

// File: rtl/dma_io_responder.sv
// Peripheral endpoint for one 8237A DMA channel.
// A local FIFO decouples the device from the DMA bus.
module dma_io_responder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MODE,
  input  logic              ENABLE,
  dma_io_responder_if.slave bus,
  input  logic [DATA_W-1:0] loc_in_data,
  input  logic              loc_in_valid,
  output logic              loc_in_ready,
  output logic [DATA_W-1:0] loc_out_data,
  output logic              loc_out_valid,
  input  logic              loc_out_ready,
  input  logic              abort,
  input  logic              clear_done,
  output logic              done,
  output logic [CNT_W-1:0]  xfer_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK,
    S_STB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_mode;
  logic              r_dreq;
  logic              r_db_oe;
  logic [DATA_W-1:0] r_db_out;
  logic [DATA_W-1:0] r_cap;
  logic              r_done;
  logic              r_abort_pend;
  logic              r_eop_seen;
  logic [CNT_W-1:0]  r_xfer;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_avail;
  logic              w_strobe;
  logic              w_eop_in;
  logic              w_abort;
  logic              w_loc_push;
  logic              w_loc_pop;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_push_data;
  logic [DATA_W-1:0] w_head;
  logic              w_bus_xfer;
  logic              w_done_set;
  logic              w_abort_take;
  logic              w_src_stb;

  assign w_full   = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_head   = r_mem[r_rd];
  assign w_avail  = r_mode ? !w_empty : !w_full;
  assign w_strobe = r_mode ? !bus.IOR_N : !bus.IOW_N;
  assign w_eop_in = bus.DACK & !bus.EOP_N_IN;
  assign w_abort  = r_abort_pend | abort;

  assign loc_in_ready  = r_mode & !w_full;
  assign loc_out_valid = !r_mode & !w_empty;
  assign loc_out_data  = w_head;

  assign w_loc_push  = loc_in_valid & loc_in_ready;
  assign w_loc_pop   = loc_out_valid & loc_out_ready;
  assign w_push      = r_mode ? w_loc_push
                              : (w_bus_xfer & !w_full);
  assign w_pop       = r_mode ? (w_bus_xfer & !w_empty)
                              : w_loc_pop;
  assign w_push_data = r_mode ? loc_in_data : r_cap;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!w_abort && ENABLE && !r_done && w_avail)
          w_next = S_REQ;
      end
      S_REQ: begin
        if (bus.DACK)     w_next = S_ACK;
        else if (!ENABLE) w_next = S_IDLE;
      end
      S_ACK: begin
        if (!bus.DACK)          w_next = S_IDLE;
        else if (w_strobe)      w_next = S_STB;
        else if (!bus.EOP_N_IN) w_next = S_IDLE;
      end
      S_STB: begin
        if (!w_strobe) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_bus_xfer   = 1'b0;
    w_done_set   = 1'b0;
    w_abort_take = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_abort_take = w_abort;
        w_done_set   = w_abort;
      end
      S_ACK: begin
        w_done_set = bus.DACK & !w_strobe
                   & !bus.EOP_N_IN;
      end
      S_STB: begin
        w_bus_xfer = !w_strobe;
        w_done_set = !w_strobe
                   & (r_eop_seen | w_eop_in);
      end
      default: ;
    endcase
  end

  assign w_src_stb = (w_next == S_STB) & r_mode;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mode       <= 1'b0;
      r_dreq       <= 1'b0;
      r_db_oe      <= 1'b0;
      r_db_out     <= '0;
      r_cap        <= '0;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_eop_seen   <= 1'b0;
      r_xfer       <= '0;
    end else begin
      if (r_state == S_IDLE) r_mode <= MODE;
      r_dreq   <= (w_next == S_REQ);
      r_db_oe  <= w_src_stb;
      r_db_out <= w_src_stb ? w_head : '0;
      if ((r_state == S_ACK || r_state == S_STB)
          && w_strobe)
        r_cap <= bus.DB_IN;
      if (w_done_set)      r_done <= 1'b1;
      else if (clear_done) r_done <= 1'b0;
      if (w_abort_take) r_abort_pend <= 1'b0;
      else if (abort)   r_abort_pend <= 1'b1;
      if (r_state == S_IDLE) r_eop_seen <= 1'b0;
      else if (w_eop_in)     r_eop_seen <= 1'b1;
      if (clear_done)
        r_xfer <= '0;
      else if (w_bus_xfer && !(&r_xfer))
        r_xfer <= r_xfer + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= w_push_data;
  end

  assign bus.DREQ      = r_dreq;
  assign bus.DB_OE     = r_db_oe;
  assign bus.DB_OUT    = r_db_out;
  // Early terminate is shown only while the controller acknowledges.
  assign bus.EOP_N_OUT = !(r_abort_pend & bus.DACK
                           & (r_state != S_IDLE));
  assign done          = r_done;
  assign xfer_count    = r_xfer;
endmodule

// File: tb/tb_dma_io_responder.sv
// Directed bench for dma_io_responder.
// Plays the DMA controller and the local device.
module tb_dma_io_responder;
  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        MODE;
  logic        ENABLE;
  logic [7:0]  loc_in_data;
  logic        loc_in_valid;
  logic        loc_in_ready;
  logic [7:0]  loc_out_data;
  logic        loc_out_valid;
  logic        loc_out_ready;
  logic        abort;
  logic        clear_done;
  logic        done;
  logic [15:0] xfer_count;

  int n_chk = 0;
  int n_err = 0;

  dma_io_responder_if #(.DATA_W(8)) bus ();

  dma_io_responder #(
    .DATA_W(8),
    .DEPTH (8),
    .CNT_W (16)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .MODE         (MODE),
    .ENABLE       (ENABLE),
    .bus          (bus.slave),
    .loc_in_data  (loc_in_data),
    .loc_in_valid (loc_in_valid),
    .loc_in_ready (loc_in_ready),
    .loc_out_data (loc_out_data),
    .loc_out_valid(loc_out_valid),
    .loc_out_ready(loc_out_ready),
    .abort        (abort),
    .clear_done   (clear_done),
    .done         (done),
    .xfer_count   (xfer_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET_N       = 1'b0;
    MODE          = 1'b0;
    ENABLE        = 1'b0;
    loc_in_data   = '0;
    loc_in_valid  = 1'b0;
    loc_out_ready = 1'b0;
    abort         = 1'b0;
    clear_done    = 1'b0;
    bus.DACK      = 1'b0;
    bus.IOR_N     = 1'b1;
    bus.IOW_N     = 1'b1;
    bus.EOP_N_IN  = 1'b1;
    bus.DB_IN     = '0;
    tick(2);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] d);
    loc_in_data  = d;
    loc_in_valid = 1'b1;
    tick();
    loc_in_valid = 1'b0;
  endtask

  task automatic wait_dreq(string tag);
    int k = 0;
    while (!bus.DREQ && k < 20) begin
      tick();
      k++;
    end
    chk(tag, bus.DREQ, 1);
  endtask

  task automatic bus_read(input  logic       eop_n,
                          output logic [7:0] d);
    bus.DACK  = 1'b1;
    tick();
    bus.IOR_N = 1'b0;
    tick();
    bus.EOP_N_IN = eop_n;
    tick();
    d = bus.DB_OUT;
    chk("rd_oe_on", bus.DB_OE, 1);
    bus.IOR_N = 1'b1;
    tick();
    chk("rd_oe_off", bus.DB_OE, 0);
    bus.EOP_N_IN = 1'b1;
    bus.DACK     = 1'b0;
    tick();
  endtask

  task automatic bus_write(input logic [7:0] d);
    bus.DACK  = 1'b1;
    tick();
    bus.IOW_N = 1'b0;
    bus.DB_IN = d;
    tick(2);
    bus.IOW_N = 1'b1;
    tick();
    bus.DACK  = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       seen;

    // T1: source, three bytes out in order
    do_reset();
    chk("rst_dreq", bus.DREQ, 0);
    chk("rst_oe", bus.DB_OE, 0);
    chk("rst_dbout", bus.DB_OUT, 0);
    chk("rst_eop", bus.EOP_N_OUT, 1);
    chk("rst_done", done, 0);
    chk("rst_cnt", xfer_count, 0);
    chk("rst_inrdy", loc_in_ready, 0);
    chk("rst_outvld", loc_out_valid, 0);
    MODE = 1'b1;
    tick();
    chk("t1_inrdy", loc_in_ready, 1);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    chk("t1_dreq_off", bus.DREQ, 0);
    ENABLE = 1'b1;
    tick(2);
    chk("t1_dreq_on", bus.DREQ, 1);
    bus_read(1'b1, d);
    chk("t1_d0", d, 8'hA1);
    wait_dreq("t1_dreq1");
    bus_read(1'b1, d);
    chk("t1_d1", d, 8'hA2);
    wait_dreq("t1_dreq2");
    bus_read(1'b1, d);
    chk("t1_d2", d, 8'hA3);
    tick(3);
    chk("t1_empty_dreq", bus.DREQ, 0);
    chk("t1_cnt", xfer_count, 3);

    // T2: sink fills the FIFO, one local pop reopens it
    do_reset();
    ENABLE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_dreq("t2_dreq");
      bus_write(8'(8'h10 + i));
    end
    tick(4);
    chk("t2_full_dreq", bus.DREQ, 0);
    chk("t2_cnt", xfer_count, 8);
    chk("t2_outvld", loc_out_valid, 1);
    chk("t2_head", loc_out_data, 8'h10);
    loc_out_ready = 1'b1;
    tick();
    loc_out_ready = 1'b0;
    chk("t2_head2", loc_out_data, 8'h11);
    wait_dreq("t2_redreq");

    // T3: EOP during second strobe
    do_reset();
    MODE = 1'b1;
    tick();
    push(8'h31);
    push(8'h32);
    push(8'h33);
    ENABLE = 1'b1;
    wait_dreq("t3_dreq");
    bus_read(1'b1, d);
    chk("t3_d0", d, 8'h31);
    chk("t3_nodone", done, 0);
    wait_dreq("t3_dreq2");
    bus_read(1'b0, d);
    chk("t3_d1", d, 8'h32);
    chk("t3_done", done, 1);
    chk("t3_cnt", xfer_count, 2);
    tick(4);
    chk("t3_blocked", bus.DREQ, 0);
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    chk("t3_clr_done", done, 0);
    chk("t3_clr_cnt", xfer_count, 0);
    wait_dreq("t3_redreq");

    // T4: abort in REQ, then abort in IDLE
    do_reset();
    MODE = 1'b1;
    tick();
    push(8'hB1);
    push(8'hB2);
    ENABLE = 1'b1;
    wait_dreq("t4_dreq");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_eop_nodack", bus.EOP_N_OUT, 1);
    bus.DACK = 1'b1;
    tick();
    chk("t4_eop_ack", bus.EOP_N_OUT, 0);
    bus.IOR_N = 1'b0;
    tick(2);
    chk("t4_eop_stb", bus.EOP_N_OUT, 0);
    chk("t4_data", bus.DB_OUT, 8'hB1);
    bus.IOR_N = 1'b1;
    tick();
    chk("t4_eop_rel", bus.EOP_N_OUT, 1);
    bus.DACK = 1'b0;
    tick();
    chk("t4_done", done, 1);
    chk("t4_cnt", xfer_count, 1);
    tick(3);
    chk("t4_blocked", bus.DREQ, 0);
    ENABLE = 1'b0;
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    chk("t4_clr", done, 0);
    abort  = 1'b1;
    ENABLE = 1'b1;
    tick();
    abort  = 1'b0;
    chk("t4_idle_done", done, 1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= bus.DREQ;
      tick();
    end
    chk("t4_idle_noreq", seen, 0);

    // T5: DACK drops before any strobe
    do_reset();
    MODE = 1'b1;
    tick();
    push(8'h55);
    ENABLE = 1'b1;
    wait_dreq("t5_dreq");
    bus.DACK = 1'b1;
    tick();
    bus.DACK = 1'b0;
    tick();
    chk("t5_idle_dreq", bus.DREQ, 0);
    chk("t5_cnt0", xfer_count, 0);
    tick();
    chk("t5_redreq", bus.DREQ, 1);
    bus_read(1'b1, d);
    chk("t5_data", d, 8'h55);
    chk("t5_cnt1", xfer_count, 1);

    // T6: reset in the middle of a strobe
    do_reset();
    MODE = 1'b1;
    tick();
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    push(8'hC4);
    ENABLE = 1'b1;
    wait_dreq("t6_dreq");
    bus.DACK = 1'b1;
    tick();
    bus.IOR_N = 1'b0;
    tick(2);
    chk("t6_oe_on", bus.DB_OE, 1);
    RESET_N = 1'b0;
    #1;
    chk("t6_rst_oe", bus.DB_OE, 0);
    chk("t6_rst_dreq", bus.DREQ, 0);
    MODE      = 1'b0;
    ENABLE    = 1'b0;
    bus.DACK  = 1'b0;
    bus.IOR_N = 1'b1;
    tick();
    RESET_N = 1'b1;
    tick();
    chk("t6_inrdy", loc_in_ready, 0);
    chk("t6_empty", loc_out_valid, 0);
    chk("t6_cnt", xfer_count, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule
